// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets and default window base for the MMIO PIO bridge
package mmio_pkg;
    localparam logic [31:0] DEFAULT_BASE = 32'hFF20_0000;
    localparam logic [7:0] OFS_LED     = 8'h00;
    localparam logic [7:0] OFS_HEX0    = 8'h20;
    localparam logic [7:0] OFS_HEX1    = 8'h30;
    localparam logic [7:0] OFS_SW      = 8'h40;
    localparam logic [7:0] OFS_KEY     = 8'h50;
    localparam logic [7:0] OFS_KEYMASK = 8'h58;
    localparam logic [7:0] OFS_EDGECAP = 8'h5C;
    localparam logic [7:0] OFS_TIMER   = 8'h60;
endpackage

// File: rtl/mmio_sync2.sv
// mmio_sync2: two-flop vector synchroniser, asynchronous reset to 0
module mmio_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/mmio_pio_bridge.sv
// mmio_pio_bridge: 256-byte MMIO window with LED/HEX/SW/KEY registers, key edge capture and IRQ.
// Define MMIO_TIMER_EN to add a free-running 32-bit cycle counter at offset 0x60.
module mmio_pio_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE,
    parameter int          LED_W     = 10,
    parameter int          SW_W      = 10,
    parameter int          KEY_W     = 2,
    parameter int          NUM_HEX   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    output logic                 hit_o,
    input  logic [SW_W-1:0]      sw_i,
    input  logic [KEY_W-1:0]     key_i,
    output logic [LED_W-1:0]     ledr_o,
    output logic [NUM_HEX*8-1:0] hex_o,
    output logic                 irq_o
);
    logic [7:0]           ofs;
    logic                 wr;
    logic [SW_W-1:0]      sw_s;
    logic [KEY_W-1:0]     key_s, key_d, mask_q, cap_q;
    logic [NUM_HEX*8-1:0] hex_q;
    logic [63:0]          hex_all;
    logic                 unused;

    assign ofs     = {addr_i[7:2], 2'b00};
    assign hit_o   = addr_i[31:8] == BASE_ADDR[31:8];
    assign wr      = we_i & hit_o;
    assign hex_o   = ~hex_q;
    assign hex_all = 64'(hex_q);
    assign irq_o   = |(cap_q & mask_q);
    assign unused  = ^{addr_i[1:0], wdata_i};

    mmio_sync2 #(.W(SW_W)) u_sw_sync (
        .clk(clk), .reset(reset), .d(sw_i), .q(sw_s)
    );

    // keys are active-low on the board; synchronise the pressed sense
    mmio_sync2 #(.W(KEY_W)) u_key_sync (
        .clk(clk), .reset(reset), .d(~key_i), .q(key_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ledr_o <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            key_d  <= '0;
        end else begin
            if (wr && ofs == OFS_LED) ledr_o <= wdata_i[LED_W-1:0];
            if (wr && ofs == OFS_KEYMASK) mask_q <= wdata_i[KEY_W-1:0];
            key_d <= key_s;
            // new press edges are ORed in after the clear, so set wins
            cap_q <= (cap_q & ~((wr && ofs == OFS_EDGECAP) ? wdata_i[KEY_W-1:0] : '0)) | (key_s & ~key_d);
        end
    end

    for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
        logic [7:0] digit;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) digit <= '0;
            else if (wr && ofs == (k < 4 ? OFS_HEX0 : OFS_HEX1)) digit <= wdata_i[8*(k%4) +: 8];
        end
        assign hex_q[8*k +: 8] = digit;
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] timer_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_q <= '0;
        else timer_q <= (wr && ofs == OFS_TIMER) ? wdata_i : timer_q + 32'd1;
    end
`endif

    always_comb begin
        rdata_o = '0;
        if (hit_o) begin
            case (ofs)
                OFS_LED:     rdata_o = 32'(ledr_o);
                OFS_HEX0:    rdata_o = hex_all[31:0];
                OFS_HEX1:    rdata_o = hex_all[63:32];
                OFS_SW:      rdata_o = 32'(sw_s);
                OFS_KEY:     rdata_o = 32'(key_s);
                OFS_KEYMASK: rdata_o = 32'(mask_q);
                OFS_EDGECAP: rdata_o = 32'(cap_q);
`ifdef MMIO_TIMER_EN
                OFS_TIMER:   rdata_o = timer_q;
`endif
                default:     rdata_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_pio_bridge.sv
// tb_mmio_pio_bridge: directed and randomized checks of mmio_pio_bridge against a register-level model
module tb_mmio_pio_bridge;
    localparam int LED_W = 10, SW_W = 10, KEY_W = 2, NUM_HEX = 6;
    localparam logic [31:0] BASE = 32'hFF20_0000;

    logic                 clk = 0, reset = 1, we_i = 0;
    logic [31:0]          addr_i = 0, wdata_i = 0;
    logic [31:0]          rdata_o;
    logic                 hit_o, irq_o;
    logic [SW_W-1:0]      sw_i = 0;
    logic [KEY_W-1:0]     key_i = '1;
    logic [LED_W-1:0]     ledr_o;
    logic [NUM_HEX*8-1:0] hex_o;

    int checks = 0, failures = 0;

    logic [LED_W-1:0] m_led;
    logic [7:0]       m_hex [8];
    logic [KEY_W-1:0] m_mask, m_cap;
    logic [SW_W-1:0]  sw_p [2];
    logic [KEY_W-1:0] key_p [3];
    logic [31:0]      m_tmr;

    mmio_pio_bridge dut (
        .clk(clk), .reset(reset), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .hit_o(hit_o), .sw_i(sw_i), .key_i(key_i),
        .ledr_o(ledr_o), .hex_o(hex_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void m_reset();
        m_led = '0; m_mask = '0; m_cap = '0; m_tmr = '0;
        for (int i = 0; i < 8; i++) m_hex[i] = '0;
        sw_p[0] = '0; sw_p[1] = '0;
        key_p[0] = '0; key_p[1] = '0; key_p[2] = '0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [7:0] o;
        if (a[31:8] != BASE[31:8]) return '0;
        o = {a[7:2], 2'b00};
        case (o)
            8'h00: return 32'(m_led);
            8'h20: return {m_hex[3], m_hex[2], m_hex[1], m_hex[0]};
            8'h30: return {m_hex[7], m_hex[6], m_hex[5], m_hex[4]};
            8'h40: return 32'(sw_p[1]);
            8'h50: return 32'(key_p[1]);
            8'h58: return 32'(m_mask);
            8'h5C: return 32'(m_cap);
`ifdef MMIO_TIMER_EN
            8'h60: return m_tmr;
`endif
            default: return '0;
        endcase
    endfunction

    function automatic logic [NUM_HEX*8-1:0] m_hexo();
        logic [NUM_HEX*8-1:0] r;
        for (int i = 0; i < NUM_HEX; i++) r[8*i +: 8] = ~m_hex[i];
        return r;
    endfunction

    // one clock edge: model next state from the pre-edge inputs, returns at posedge+1
    task automatic cycle();
        logic w;
        logic [7:0] o;
        int base;
        logic [LED_W-1:0] n_led;
        logic [7:0] n_hex [8];
        logic [KEY_W-1:0] n_mask, n_cap, k_in;
        logic [SW_W-1:0] s_in;
        logic [31:0] n_tmr;
        w = we_i && (addr_i[31:8] == BASE[31:8]);
        o = {addr_i[7:2], 2'b00};
        base = (o == 8'h30) ? 4 : 0;
        n_led = (w && o == 8'h00) ? wdata_i[LED_W-1:0] : m_led;
        n_hex = m_hex;
        if (w && (o == 8'h20 || o == 8'h30))
            for (int b = 0; b < 4; b++)
                if (base + b < NUM_HEX) n_hex[base + b] = wdata_i[8*b +: 8];
        n_mask = (w && o == 8'h58) ? wdata_i[KEY_W-1:0] : m_mask;
        n_cap = (m_cap & ~((w && o == 8'h5C) ? wdata_i[KEY_W-1:0] : '0)) | (key_p[1] & ~key_p[2]);
        n_tmr = (w && o == 8'h60) ? wdata_i : m_tmr + 32'd1;
        s_in = sw_i;
        k_in = ~key_i;
        @(posedge clk);
        #1;
        m_led = n_led; m_hex = n_hex; m_mask = n_mask; m_cap = n_cap; m_tmr = n_tmr;
        sw_p[1] = sw_p[0]; sw_p[0] = s_in;
        key_p[2] = key_p[1]; key_p[1] = key_p[0]; key_p[0] = k_in;
    endtask

    task automatic write(input logic [7:0] o, input logic [31:0] d);
        addr_i = BASE + 32'(o); wdata_i = d; we_i = 1;
        cycle();
        we_i = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        addr_i = BASE + 32'h5C;
        #1;
        checks++; if (ledr_o !== '0) begin failures++; $display("FAIL reset_led got=%h exp=0", ledr_o); end
        checks++; if (hex_o !== 48'hFFFF_FFFF_FFFF) begin failures++; $display("FAIL reset_hex got=%h exp=ffffffffffff", hex_o); end
        checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
        checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL reset_edgecap got=%h exp=0", rdata_o); end
        reset = 0;
    endtask

    task automatic test_led_hex();
        addr_i = BASE; wdata_i = 32'h3FF; we_i = 1;
        #1;
        checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL write_cycle_read got=%h exp=0", rdata_o); end
        cycle();
        we_i = 0;
        #1;
        checks++; if (ledr_o !== 10'h3FF) begin failures++; $display("FAIL led_write got=%h exp=3ff", ledr_o); end
        write(8'h20, 32'h1234_5678);
        #1;
        checks++; if (hex_o[31:0] !== 32'hEDCB_A987) begin failures++; $display("FAIL hex0_drive got=%h exp=edcba987", hex_o[31:0]); end
        write(8'h30, 32'hFFFF_FFFF);
        #1;
        checks++; if (rdata_o !== 32'h0000_FFFF) begin failures++; $display("FAIL hex1_read got=%h exp=0000ffff", rdata_o); end
        checks++; if (hex_o !== 48'h0000_EDCB_A987) begin failures++; $display("FAIL hex_all got=%h exp=0000edcba987", hex_o); end
    endtask

    task automatic test_sw();
        sw_i = 10'h2A5; addr_i = BASE + 32'h40;
        cycle(); #1;
        checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL sw_one_edge got=%h exp=0", rdata_o); end
        cycle(); #1;
        checks++; if (rdata_o !== 32'h2A5) begin failures++; $display("FAIL sw_two_edges got=%h exp=2a5", rdata_o); end
        addr_i = BASE + 32'h100; #1;
        checks++; if (hit_o !== 1'b0) begin failures++; $display("FAIL hit_above got=%b exp=0", hit_o); end
        addr_i = BASE - 32'h4; #1;
        checks++; if (hit_o !== 1'b0) begin failures++; $display("FAIL hit_below got=%b exp=0", hit_o); end
        addr_i = BASE + 32'hFC; #1;
        checks++; if (hit_o !== 1'b1 || rdata_o !== 32'h0) begin failures++; $display("FAIL hit_top got=%b/%h exp=1/0", hit_o, rdata_o); end
    endtask

    task automatic test_keys();
        write(8'h58, 32'h1);
        key_i = 2'b10; addr_i = BASE + 32'h50;
        cycle(); #1;
        checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL key_edge_n got=%h exp=0", rdata_o); end
        cycle(); #1;
        checks++; if (rdata_o !== 32'h1 || irq_o !== 1'b0) begin failures++; $display("FAIL key_edge_n1 got=%h/%b exp=1/0", rdata_o, irq_o); end
        addr_i = BASE + 32'h5C;
        cycle(); #1;
        checks++; if (rdata_o !== 32'h1 || irq_o !== 1'b1) begin failures++; $display("FAIL cap_edge_n2 got=%h/%b exp=1/1", rdata_o, irq_o); end
        key_i = 2'b11;
        repeat (4) cycle();
        #1;
        checks++; if (rdata_o !== 32'h1) begin failures++; $display("FAIL release_ignored got=%h exp=1", rdata_o); end
        write(8'h5C, 32'h0);
        #1;
        checks++; if (rdata_o !== 32'h1) begin failures++; $display("FAIL w0_no_effect got=%h exp=1", rdata_o); end
        write(8'h5C, 32'h1);
        #1;
        checks++; if (rdata_o !== 32'h0 || irq_o !== 1'b0) begin failures++; $display("FAIL w1c got=%h/%b exp=0/0", rdata_o, irq_o); end
    endtask

    task automatic test_w1c_collision();
        key_i = 2'b10;
        repeat (3) cycle();
        key_i = 2'b11;
        repeat (4) cycle();
        key_i = 2'b10;
        repeat (2) cycle();
        write(8'h5C, 32'h1);
        #1;
        checks++; if (rdata_o !== 32'h1 || rdata_o !== m_read(addr_i)) begin failures++; $display("FAIL set_wins got=%h exp=1", rdata_o); end
        key_i = 2'b11;
        repeat (3) cycle();
        write(8'h5C, 32'h3);
    endtask

    task automatic test_timer();
`ifdef MMIO_TIMER_EN
        write(8'h60, 32'hFFFF_FFFE);
        #1;
        checks++; if (rdata_o !== 32'hFFFF_FFFE) begin failures++; $display("FAIL timer_load got=%h exp=fffffffe", rdata_o); end
        cycle(); #1;
        checks++; if (rdata_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL timer_inc got=%h exp=ffffffff", rdata_o); end
        cycle(); #1;
        checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL timer_wrap got=%h exp=0", rdata_o); end
`else
        write(8'h60, $urandom | 32'h1);
        #1;
        checks++; if (rdata_o !== 32'h0) begin failures++; $display("FAIL timer_absent got=%h exp=0", rdata_o); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] ofs_tab [10] = '{8'h00, 8'h20, 8'h30, 8'h40, 8'h50, 8'h58, 8'h5C, 8'h60, 8'h10, 8'hFC};
        logic [31:0] exp;
        for (int i = 0; i < 300; i++) begin
            sw_i = SW_W'($urandom);
            if ($urandom_range(0, 3) == 0) key_i = KEY_W'($urandom);
            we_i = $urandom_range(0, 1) == 1;
            wdata_i = $urandom;
            case ($urandom_range(0, 5))
                0:       addr_i = $urandom;
                1:       addr_i = BASE + 32'($urandom_range(0, 255));
                default: addr_i = BASE + 32'(ofs_tab[$urandom_range(0, 9)]) + 32'($urandom_range(0, 3));
            endcase
            #1;
            exp = m_read(addr_i);
            checks++; if (rdata_o !== exp) begin failures++; $display("FAIL rand_read[%0d] addr=%h got=%h exp=%h", i, addr_i, rdata_o, exp); end
            checks++; if (hit_o !== (addr_i[31:8] == BASE[31:8])) begin failures++; $display("FAIL rand_hit[%0d] addr=%h got=%b", i, addr_i, hit_o); end
            cycle();
            #1;
            checks++; if (ledr_o !== m_led || hex_o !== m_hexo() || irq_o !== |(m_cap & m_mask)) begin
                failures++;
                $display("FAIL rand_outputs[%0d] got=%h/%h/%b exp=%h/%h/%b", i, ledr_o, hex_o, irq_o, m_led, m_hexo(), |(m_cap & m_mask));
            end
        end
        we_i = 0;
    endtask

    task automatic test_reset_mid();
        write(8'h00, 32'h155);
        write(8'h58, 32'h3);
        key_i = 2'b00;
        repeat (3) cycle();
        addr_i = BASE + 32'h5C;
        #1;
        checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%b exp=1", irq_o); end
        we_i = 1; wdata_i = 32'h3FF; addr_i = BASE;
        #2;
        reset = 1;
        #1;
        addr_i = BASE + 32'h5C;
        #1;
        checks++; if (ledr_o !== '0 || hex_o !== 48'hFFFF_FFFF_FFFF) begin failures++; $display("FAIL mid_reset_regs got=%h/%h exp=0/ffffffffffff", ledr_o, hex_o); end
        checks++; if (irq_o !== 1'b0 || rdata_o !== 32'h0) begin failures++; $display("FAIL mid_reset_cap got=%b/%h exp=0/0", irq_o, rdata_o); end
        we_i = 0; key_i = '1;
        @(posedge clk); #3;
        m_reset();
        reset = 0;
        cycle(); #1;
        checks++; if (ledr_o !== '0 || rdata_o !== m_read(addr_i)) begin failures++; $display("FAIL post_reset got=%h/%h exp=0/%h", ledr_o, rdata_o, m_read(addr_i)); end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_led_hex();
        test_sw();
        test_keys();
        test_w1c_collision();
        test_timer();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
